alu_share_arbiter: RTL and testbench

- Shares one combinational ALU between NUM_REQ requesters (e.g. a main integer pipe and a branch/address unit).
- Each requester presents an operation through a valid/ready request port.
- The block round-robin arbitrates among them, drives the ALU control/operand bus for the winner, and registers the result into that requester's response slot.
- Response slots use valid/ready handshakes; a full, undrained slot blocks further grants to its owner.

---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 106 ++++++++++
 tb/tb_alu_share_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: ALU control codes and illegal-op decode.
// The illegal-op decode is only consulted when ALU_ARB_ILLEGAL_OP_EN is defined.
package alu_arb_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t ALU_ADD  = 4'b0000;
   localparam alu_op_t ALU_SUB  = 4'b0001;
   localparam alu_op_t ALU_AND  = 4'b0010;
   localparam alu_op_t ALU_OR   = 4'b0011;
   localparam alu_op_t ALU_XOR  = 4'b0100;
   localparam alu_op_t ALU_SLL  = 4'b0101;
   localparam alu_op_t ALU_SRL  = 4'b0110;
   localparam alu_op_t ALU_SRA  = 4'b0111;
   localparam alu_op_t ALU_SLT  = 4'b1000;
   localparam alu_op_t ALU_SLTU = 4'b1001;
   localparam alu_op_t ALU_EQ   = 4'b1010;
   localparam alu_op_t ALU_NE   = 4'b1011;
   localparam alu_op_t ALU_GE   = 4'b1100;
   localparam alu_op_t ALU_GEU  = 4'b1101;

   localparam alu_op_t ILLEGAL_OP_MIN = 4'b1110;

   // Codes at or above ILLEGAL_OP_MIN are reserved and never reach the ALU.
   function automatic logic is_illegal_op(input alu_op_t op);
      return (op >= ILLEGAL_OP_MIN);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant to the first eligible index at or after
// the pointer; the pointer moves to one past the winner.  Reusable for other shared units.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] eligible,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW:0]   w_sum;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_win;
   logic          w_found;

   always_comb begin
      grant   = '0;
      w_sum   = '0;
      w_idx   = '0;
      w_win   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(N)) begin
            w_sum = w_sum - (PW+1)'(N);
         end
         w_idx = w_sum[PW-1:0];
         if (!w_found && eligible[w_idx]) begin
            grant[w_idx] = 1'b1;
            w_win        = w_idx;
            w_found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= (w_win == PW'(N-1)) ? '0 : w_win + 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin arbitration
// and per-requester registered response slots.  Optional macro: ALU_ARB_ILLEGAL_OP_EN.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [4*NUM_REQ-1:0]    req_op,
   input  logic [XLEN*NUM_REQ-1:0] req_a,
   input  logic [XLEN*NUM_REQ-1:0] req_b,
   output logic [3:0]              alu_control,
   output logic [XLEN-1:0]         alu_srca,
   output logic [XLEN-1:0]         alu_srcb,
   input  logic [XLEN-1:0]         alu_result,
   input  logic                    alu_zero,
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic [XLEN*NUM_REQ-1:0] rsp_result,
   output logic [NUM_REQ-1:0]      rsp_zero,
   output logic [NUM_REQ-1:0]      rsp_err
);

   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic [XLEN*NUM_REQ-1:0] r_rsp_result;
   logic [NUM_REQ-1:0]      r_rsp_zero;
   logic [NUM_REQ-1:0]      r_rsp_err;

   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_grant;
   alu_op_t            w_op;
   logic [XLEN-1:0]    w_a;
   logic [XLEN-1:0]    w_b;
   logic               w_illegal;
   logic [XLEN-1:0]    w_ld_result;
   logic               w_ld_zero;

   // A full slot being drained this cycle can accept a new result without a bubble.
   assign w_eligible = req_valid & (~r_rsp_valid | rsp_ready);

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk      (clk),
      .reset    (reset),
      .eligible (w_eligible),
      .grant    (w_grant)
   );

   assign req_ready = w_grant;

   // Grant is one-hot or zero, so an idle cycle leaves the bus at all-zero.
   always_comb begin
      w_op = '0;
      w_a  = '0;
      w_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_op = req_op[4*i +: 4];
            w_a  = req_a[XLEN*i +: XLEN];
            w_b  = req_b[XLEN*i +: XLEN];
         end
      end
   end

`ifdef ALU_ARB_ILLEGAL_OP_EN
   assign w_illegal = is_illegal_op(w_op);
`else
   assign w_illegal = 1'b0;
`endif

   assign alu_control = w_illegal ? ALU_ADD : w_op;
   assign alu_srca    = w_illegal ? '0 : w_a;
   assign alu_srcb    = w_illegal ? '0 : w_b;

   assign w_ld_result = w_illegal ? '0   : alu_result;
   assign w_ld_zero   = w_illegal ? 1'b1 : alu_zero;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_zero   <= '0;
         r_rsp_err    <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
               r_rsp_valid[i]               <= 1'b1;
               r_rsp_result[XLEN*i +: XLEN] <= w_ld_result;
               r_rsp_zero[i]                <= w_ld_zero;
               r_rsp_err[i]                 <= w_illegal;
            end else if (r_rsp_valid[i] && rsp_ready[i]) begin
               r_rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, directed corner sequences,
// and randomized traffic against a requester-level reference model.
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   localparam int NREQ = 2;
   localparam int XL   = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_op;
   logic [XL*NREQ-1:0] req_a;
   logic [XL*NREQ-1:0] req_b;
   logic [3:0]        alu_control;
   logic [XL-1:0]     alu_srca;
   logic [XL-1:0]     alu_srcb;
   logic [XL-1:0]     alu_result;
   logic              alu_zero;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [XL*NREQ-1:0] rsp_result;
   logic [NREQ-1:0]   rsp_zero;
   logic [NREQ-1:0]   rsp_err;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NUM_REQ(NREQ), .XLEN(XL)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .alu_control (alu_control),
      .alu_srca    (alu_srca),
      .alu_srcb    (alu_srcb),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_zero    (rsp_zero),
      .rsp_err     (rsp_err)
   );

   // Behavioural ALU on the shared bus; unknown codes return all ones.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         ALU_EQ:   return {31'd0, a == b};
         ALU_NE:   return {31'd0, a != b};
         ALU_GE:   return {31'd0, $signed(a) >= $signed(b)};
         ALU_GEU:  return {31'd0, a >= b};
         default:  return 32'hFFFF_FFFF;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_control, alu_srca, alu_srcb);
   assign alu_zero   = (alu_result == 32'd0);

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic op_is_illegal(input logic [3:0] op);
`ifdef ALU_ARB_ILLEGAL_OP_EN
      return (op == 4'hE) || (op == 4'hF);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      return op_is_illegal(op) ? 32'd0 : alu_fn(op, a, b);
   endfunction

   logic [3:0]  cur_op [NREQ];
   logic [31:0] cur_a  [NREQ];
   logic [31:0] cur_b  [NREQ];

   task automatic drive(input logic [1:0] v, input logic [1:0] r,
                        input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
      cur_op[0] = o0; cur_a[0] = a0; cur_b[0] = b0;
      cur_op[1] = o1; cur_a[1] = a1; cur_b[1] = b1;
      req_valid = v;
      rsp_ready = r;
      req_op    = {o1, o0};
      req_a     = {a1, a0};
      req_b     = {b1, b0};
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one time unit after a rising edge with reset released.
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      drive(2'b00, 2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Requester-level reference model.
   int          m_ptr;
   logic [1:0]  m_valid;
   logic [31:0] m_res  [NREQ];
   logic [1:0]  m_zero;
   logic [1:0]  m_err;

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = '0;
      m_zero  = '0;
      m_err   = '0;
      for (int i = 0; i < NREQ; i++) m_res[i] = '0;
   endtask

   function automatic logic [1:0] model_grant(input logic [1:0] v, input logic [1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (v[idx] && (!m_valid[idx] || r[idx])) return 2'(1 << idx);
      end
      return 2'b00;
   endfunction

   task automatic model_commit(input logic [1:0] g, input logic [1:0] r);
      for (int i = 0; i < NREQ; i++) begin
         if (g[i]) begin
            m_valid[i] = 1'b1;
            m_res[i]   = exp_result(cur_op[i], cur_a[i], cur_b[i]);
            m_zero[i]  = op_is_illegal(cur_op[i]) ? 1'b1 : (m_res[i] == 32'd0);
            m_err[i]   = op_is_illegal(cur_op[i]);
            m_ptr      = (i + 1) % NREQ;
         end else if (m_valid[i] && r[i]) begin
            m_valid[i] = 1'b0;
         end
      end
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  r;
      logic [3:0]  o0;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [3:0]  o1;
      logic [31:0] a1;
      logic [31:0] b1;
      logic [1:0]  e_ready;
      logic [1:0]  e_rvalid;
      logic [1:0]  e_zero;
      logic [31:0] e_res0;
      logic [31:0] e_res1;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] v, input logic [1:0] r,
                               input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] er, input logic [1:0] ev, input logic [1:0] ez,
                               input logic [31:0] e0, input logic [31:0] e1);
      vec_t t;
      t.v = v; t.r = r; t.o0 = o0; t.a0 = a0; t.b0 = b0; t.o1 = o1; t.a1 = a1; t.b1 = b1;
      t.e_ready = er; t.e_rvalid = ev; t.e_zero = ez; t.e_res0 = e0; t.e_res1 = e1;
      return t;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [1:0]  g;
      logic [1:0]  v;
      logic [1:0]  r;
      logic [3:0]  ro [NREQ];
      logic [31:0] ra [NREQ];
      logic [31:0] rb [NREQ];
      int          w;
      logic [3:0]  x_ctl;
      logic [31:0] x_opnd;
      logic [31:0] x_res;
      logic        x_zero;
      logic        x_err;

      // Applied in order from reset; each row's expectation follows from the rows before it.
      vecs.push_back(mk(2'b01, 2'b00, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0,
                        2'b01, 2'b01, 2'b00, 32'd12, 32'd0));
      vecs.push_back(mk(2'b11, 2'b01, ALU_SUB, 32'd3, 32'd3, ALU_ADD, 32'd10, 32'd20,
                        2'b10, 2'b10, 2'b00, 32'd12, 32'd30));
      vecs.push_back(mk(2'b11, 2'b11, ALU_SUB, 32'd3, 32'd3, ALU_XOR, 32'd5, 32'd5,
                        2'b01, 2'b01, 2'b01, 32'd0, 32'd30));
      vecs.push_back(mk(2'b11, 2'b00, ALU_ADD, 32'd1, 32'd1, ALU_OR, 32'hF0, 32'h0F,
                        2'b10, 2'b11, 2'b01, 32'd0, 32'hFF));
      vecs.push_back(mk(2'b11, 2'b00, ALU_ADD, 32'd1, 32'd1, ALU_OR, 32'h1, 32'h1,
                        2'b00, 2'b11, 2'b01, 32'd0, 32'hFF));
      vecs.push_back(mk(2'b00, 2'b10, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0,
                        2'b00, 2'b01, 2'b01, 32'd0, 32'hFF));
      vecs.push_back(mk(2'b10, 2'b01, ALU_ADD, 32'd0, 32'd0, ALU_SLTU, 32'd1, 32'd2,
                        2'b10, 2'b10, 2'b01, 32'd0, 32'd1));
      vecs.push_back(mk(2'b11, 2'b10, ALU_AND, 32'hFF, 32'h0F, ALU_SUB, 32'd10, 32'd3,
                        2'b01, 2'b01, 2'b00, 32'h0F, 32'd1));

      reset = 1'b1;
      drive(2'b00, 2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_result", 64'(rsp_result), 64'd0);
      check("reset rsp_zero", 64'(rsp_zero), 64'd0);
      check("reset rsp_err", 64'(rsp_err), 64'd0);
      reset = 1'b0;
      drive(2'b00, 2'b00, ALU_SUB, 32'd9, 32'd9, ALU_SUB, 32'd9, 32'd9);
      @(negedge clk);
      check("idle req_ready", 64'(req_ready), 64'd0);
      check("idle alu_control", 64'(alu_control), 64'd0);
      check("idle alu_srca", 64'(alu_srca), 64'd0);
      check("idle alu_srcb", 64'(alu_srcb), 64'd0);
      next_edge();

      // Vector table
      foreach (vecs[n]) begin
         drive(vecs[n].v, vecs[n].r, vecs[n].o0, vecs[n].a0, vecs[n].b0,
               vecs[n].o1, vecs[n].a1, vecs[n].b1);
         @(negedge clk);
         check($sformatf("vec%0d req_ready", n), 64'(req_ready), 64'(vecs[n].e_ready));
         next_edge();
         check($sformatf("vec%0d rsp_valid", n), 64'(rsp_valid), 64'(vecs[n].e_rvalid));
         check($sformatf("vec%0d rsp_zero", n), 64'(rsp_zero), 64'(vecs[n].e_zero));
         check($sformatf("vec%0d result0", n), 64'(rsp_result[31:0]), 64'(vecs[n].e_res0));
         check($sformatf("vec%0d result1", n), 64'(rsp_result[63:32]), 64'(vecs[n].e_res1));
         check($sformatf("vec%0d rsp_err", n), 64'(rsp_err), 64'd0);
      end

      // Backpressure on slot 1, then release with same-cycle refill.
      do_reset();
      drive(2'b10, 2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd2, 32'd3);
      @(negedge clk);
      check("bp fill ready", 64'(req_ready), 64'b10);
      next_edge();
      check("bp fill result", 64'(rsp_result[63:32]), 64'd5);
      for (int c = 0; c < 4; c++) begin
         drive(2'b10, 2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd4, 32'd4);
         @(negedge clk);
         check($sformatf("bp stall%0d ready", c), 64'(req_ready), 64'd0);
         next_edge();
         check($sformatf("bp stall%0d valid", c), 64'(rsp_valid[1]), 64'd1);
         check($sformatf("bp stall%0d data", c), 64'(rsp_result[63:32]), 64'd5);
      end
      drive(2'b10, 2'b10, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd4, 32'd4);
      @(negedge clk);
      check("bp release ready", 64'(req_ready), 64'b10);
      check("bp release valid held", 64'(rsp_valid[1]), 64'd1);
      next_edge();
      check("bp refill valid", 64'(rsp_valid[1]), 64'd1);
      check("bp refill data", 64'(rsp_result[63:32]), 64'd8);

      // Fairness: req 0 always valid, req 1 arrives while the pointer is at 0.
      do_reset();
      drive(2'b11, 2'b11, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 32'd2, 32'd2);
      @(negedge clk);
      check("fair c0 grant", 64'(req_ready), 64'b01);
      next_edge();
      drive(2'b11, 2'b11, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 32'd2, 32'd2);
      @(negedge clk);
      check("fair c1 grant", 64'(req_ready), 64'b10);
      next_edge();
      check("fair req1 result", 64'(rsp_result[63:32]), 64'd4);

      // Asynchronous reset between edges with both slots full and pointer at 1.
      do_reset();
      drive(2'b11, 2'b00, ALU_ADD, 32'd1, 32'd2, ALU_ADD, 32'd3, 32'd4);
      next_edge();
      drive(2'b10, 2'b00, ALU_ADD, 32'd1, 32'd2, ALU_ADD, 32'd3, 32'd4);
      next_edge();
      drive(2'b01, 2'b01, ALU_ADD, 32'd5, 32'd5, ALU_ADD, 32'd3, 32'd4);
      @(negedge clk);
      check("rst pre grant", 64'(req_ready), 64'b01);
      next_edge();
      check("rst pre full", 64'(rsp_valid), 64'b11);
      drive(2'b00, 2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0);
      #1;
      reset = 1'b1;
      #1;
      check("rst async valid", 64'(rsp_valid), 64'd0);
      check("rst async result", 64'(rsp_result), 64'd0);
      #1;
      reset = 1'b0;
      drive(2'b11, 2'b00, ALU_ADD, 32'd6, 32'd1, ALU_ADD, 32'd0, 32'd0);
      @(negedge clk);
      check("rst post grant", 64'(req_ready), 64'b01);
      next_edge();
      check("rst post result", 64'(rsp_result[31:0]), 64'd7);

      // Reserved opcode.
      do_reset();
`ifdef ALU_ARB_ILLEGAL_OP_EN
      x_ctl = 4'h0; x_opnd = 32'd0; x_res = 32'd0; x_zero = 1'b1; x_err = 1'b1;
`else
      x_ctl = 4'hF; x_opnd = 32'd1; x_res = 32'hFFFF_FFFF; x_zero = 1'b0; x_err = 1'b0;
`endif
      drive(2'b01, 2'b00, 4'hF, 32'd1, 32'd1, ALU_ADD, 32'd0, 32'd0);
      @(negedge clk);
      check("illop ready", 64'(req_ready), 64'b01);
      check("illop alu_control", 64'(alu_control), 64'(x_ctl));
      check("illop alu_srca", 64'(alu_srca), 64'(x_opnd));
      check("illop alu_srcb", 64'(alu_srcb), 64'(x_opnd));
      next_edge();
      check("illop rsp_valid", 64'(rsp_valid), 64'b01);
      check("illop rsp_result", 64'(rsp_result[31:0]), 64'(x_res));
      check("illop rsp_zero", 64'(rsp_zero[0]), 64'(x_zero));
      check("illop rsp_err", 64'(rsp_err[0]), 64'(x_err));

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) begin
         v = 2'($urandom_range(0, 3));
         r = 2'($urandom_range(0, 3));
         for (int i = 0; i < NREQ; i++) begin
            ro[i] = 4'($urandom_range(0, 15));
            ra[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom);
            rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : 32'($urandom_range(0, 40));
         end
         drive(v, r, ro[0], ra[0], rb[0], ro[1], ra[1], rb[1]);
         g = model_grant(v, r);
         @(negedge clk);
         check($sformatf("rnd%0d req_ready", c), 64'(req_ready), 64'(g));
         w = g[1] ? 1 : 0;
         if (g != 2'b00) begin
            check($sformatf("rnd%0d alu_control", c), 64'(alu_control),
                  64'(op_is_illegal(cur_op[w]) ? 4'h0 : cur_op[w]));
            check($sformatf("rnd%0d alu_srca", c), 64'(alu_srca),
                  64'(op_is_illegal(cur_op[w]) ? 32'd0 : cur_a[w]));
            check($sformatf("rnd%0d alu_srcb", c), 64'(alu_srcb),
                  64'(op_is_illegal(cur_op[w]) ? 32'd0 : cur_b[w]));
         end else begin
            check($sformatf("rnd%0d idle bus", c), {alu_control, 60'd0} | 64'(alu_srca | alu_srcb),
                  64'd0);
         end
         model_commit(g, r);
         next_edge();
         check($sformatf("rnd%0d rsp_valid", c), 64'(rsp_valid), 64'(m_valid));
         check($sformatf("rnd%0d rsp_zero", c), 64'(rsp_zero), 64'(m_zero));
         check($sformatf("rnd%0d rsp_err", c), 64'(rsp_err), 64'(m_err));
         for (int i = 0; i < NREQ; i++) begin
            check($sformatf("rnd%0d result%0d", c, i), 64'(rsp_result[32*i +: 32]), 64'(m_res[i]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
